// File: rtl/dpram_fifo_ctrl_if.sv
// Handshake and RAM-side bundle for dpram_fifo_ctrl.
// DPRAM_FIFO_ERR_EN adds err_clr/overflow/underflow.
interface dpram_fifo_ctrl_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic                  wr_req;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_req;
  logic                  flush;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  ram_write_en;
  logic [ADDR_WIDTH-1:0] ram_waddr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic                  ram_read_en;
  logic [ADDR_WIDTH-1:0] ram_raddr;
  logic [DATA_WIDTH-1:0] ram_rdata;
`ifdef DPRAM_FIFO_ERR_EN
  logic                  err_clr;
  logic                  overflow;
  logic                  underflow;

  modport slave (
    input  wr_req, wr_data, rd_req, flush,
    input  ram_rdata, err_clr,
    output rd_data, rd_valid, full, empty,
    output almost_full, almost_empty, count,
    output ram_write_en, ram_waddr, ram_wdata,
    output ram_read_en, ram_raddr,
    output overflow, underflow
  );

  modport master (
    output wr_req, wr_data, rd_req, flush,
    output ram_rdata, err_clr,
    input  rd_data, rd_valid, full, empty,
    input  almost_full, almost_empty, count,
    input  ram_write_en, ram_waddr, ram_wdata,
    input  ram_read_en, ram_raddr,
    input  overflow, underflow
  );
`else
  modport slave (
    input  wr_req, wr_data, rd_req, flush,
    input  ram_rdata,
    output rd_data, rd_valid, full, empty,
    output almost_full, almost_empty, count,
    output ram_write_en, ram_waddr, ram_wdata,
    output ram_read_en, ram_raddr
  );

  modport master (
    output wr_req, wr_data, rd_req, flush,
    output ram_rdata,
    input  rd_data, rd_valid, full, empty,
    input  almost_full, almost_empty, count,
    input  ram_write_en, ram_waddr, ram_wdata,
    input  ram_read_en, ram_raddr
  );
`endif
endinterface

// File: rtl/dpram_fifo_ctrl.sv
// Circular-buffer FIFO controller for a 1-cycle-latency dual-port RAM.
// Optional sticky overflow/underflow flags under DPRAM_FIFO_ERR_EN.
module dpram_fifo_ctrl #(
  parameter int ADDR_WIDTH    = 8,
  parameter int DATA_WIDTH    = 8,
  parameter int AFULL_THRESH  = 252,
  parameter int AEMPTY_THRESH = 4
) (
  input logic               clk,
  input logic               rst_n,
  dpram_fifo_ctrl_if.slave  bus
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] FULL_CNT = PW'(1 << ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] AF_CNT   = PW'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH:0] AE_CNT   = PW'(AEMPTY_THRESH);

  logic [ADDR_WIDTH:0] wptr;
  logic [ADDR_WIDTH:0] rptr;
  logic [ADDR_WIDTH:0] cnt;
  logic                rvld;
  logic                full;
  logic                empty;
  logic                push;
  logic                pop;

  assign full  = (cnt == FULL_CNT);
  assign empty = (cnt == '0);

  // Strobes are held off while in reset so the RAM sees no stray access.
  assign push = rst_n & bus.wr_req & ~full & ~bus.flush;
  assign pop  = rst_n & bus.rd_req & ~empty & ~bus.flush;

  assign bus.ram_write_en = push;
  assign bus.ram_waddr    = wptr[ADDR_WIDTH-1:0];
  assign bus.ram_wdata    = bus.wr_data;
  assign bus.ram_read_en  = pop;
  assign bus.ram_raddr    = rptr[ADDR_WIDTH-1:0];

  assign bus.rd_data      = bus.ram_rdata;
  assign bus.rd_valid     = rvld;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (cnt >= AF_CNT);
  assign bus.almost_empty = (cnt <= AE_CNT);
  assign bus.count        = cnt;

  // Pointer, occupancy and read-valid state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
      rvld <= 1'b0;
    end else begin
      rvld <= pop;
      if (bus.flush) begin
        wptr <= '0;
        rptr <= '0;
        cnt  <= '0;
      end else begin
        if (push) wptr <= wptr + 1'b1;
        if (pop)  rptr <= rptr + 1'b1;
        if (push && !pop)      cnt <= cnt + 1'b1;
        else if (pop && !push) cnt <= cnt - 1'b1;
      end
    end
  end

`ifdef DPRAM_FIFO_ERR_EN
  logic ovf;
  logic unf;
  logic ovf_set;
  logic unf_set;
  logic err_clear;

  assign ovf_set   = bus.wr_req & full & ~bus.flush;
  assign unf_set   = bus.rd_req & empty & ~bus.flush;
  assign err_clear = bus.err_clr | bus.flush;

  assign bus.overflow  = ovf;
  assign bus.underflow = unf;

  // Sticky error flags; a new error wins over a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      if (ovf_set)        ovf <= 1'b1;
      else if (err_clear) ovf <= 1'b0;
      if (unf_set)        unf <= 1'b1;
      else if (err_clear) unf <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Directed self-checking bench for dpram_fifo_ctrl.
// Includes a behavioural registered-read RAM.
module tb_dpram_fifo_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  dpram_fifo_ctrl_if #(.ADDR_WIDTH(3), .DATA_WIDTH(8)) bus ();

  dpram_fifo_ctrl #(
    .ADDR_WIDTH(3),
    .DATA_WIDTH(8),
    .AFULL_THRESH(6),
    .AEMPTY_THRESH(1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave)
  );

  logic [7:0] mem [8];

  always @(posedge clk) begin
    if (bus.ram_write_en) mem[bus.ram_waddr] <= bus.ram_wdata;
    if (bus.ram_read_en)  bus.ram_rdata <= mem[bus.ram_raddr];
  end

  task automatic set_in(input logic w, input logic [7:0] d,
                        input logic r, input logic f);
    bus.wr_req  = w;
    bus.wr_data = d;
    bus.rd_req  = r;
    bus.flush   = f;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    set_in(1'b1, 8'hAA, 1'b0, 1'b0);
    tick();
    set_in(1'b1, 8'hBB, 1'b1, 1'b0);
    tick();
    n_chk++;
    if (bus.rd_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_rst_rvld: got %b want 1", bus.rd_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (bus.count !== 4'd0) begin
      n_fail++;
      $display("FAIL rst_count: got %0d want 0", bus.count);
    end
    n_chk++;
    if (bus.empty !== 1'b1 || bus.full !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_flags: got e=%b f=%b want e=1 f=0",
               bus.empty, bus.full);
    end
    n_chk++;
    if (bus.almost_empty !== 1'b1 || bus.almost_full !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_aflags: got ae=%b af=%b want ae=1 af=0",
               bus.almost_empty, bus.almost_full);
    end
    n_chk++;
    if (bus.rd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_rvld: got %b want 0", bus.rd_valid);
    end
    n_chk++;
    if (bus.ram_write_en !== 1'b0 || bus.ram_read_en !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_strobes: got we=%b re=%b want 0 0",
               bus.ram_write_en, bus.ram_read_en);
    end
    set_in(1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 8; i++) begin
      set_in(1'b1, 8'(16 + i), 1'b0, 1'b0);
      #1;
      n_chk++;
      if (bus.ram_write_en !== 1'b1 || bus.ram_waddr !== 3'(i) ||
          bus.ram_wdata !== 8'(16 + i)) begin
        n_fail++;
        $display("FAIL fill_strobe[%0d]: got we=%b a=%0d d=%h", i,
                 bus.ram_write_en, bus.ram_waddr, bus.ram_wdata);
      end
      tick();
      n_chk++;
      if (bus.count !== 4'(i + 1) ||
          bus.almost_full !== ((i + 1) >= 6) ||
          bus.full !== ((i + 1) == 8)) begin
        n_fail++;
        $display("FAIL fill_cnt[%0d]: got c=%0d af=%b f=%b", i,
                 bus.count, bus.almost_full, bus.full);
      end
    end
    set_in(1'b1, 8'hFF, 1'b0, 1'b0);
    #1;
    n_chk++;
    if (bus.ram_write_en !== 1'b0) begin
      n_fail++;
      $display("FAIL push_full_we: got %b want 0", bus.ram_write_en);
    end
    tick();
    n_chk++;
    if (bus.count !== 4'd8) begin
      n_fail++;
      $display("FAIL push_full_cnt: got %0d want 8", bus.count);
    end
    for (int i = 0; i < 8; i++) begin
      set_in(1'b0, 8'h00, 1'b1, 1'b0);
      #1;
      n_chk++;
      if (bus.ram_read_en !== 1'b1 || bus.ram_raddr !== 3'(i)) begin
        n_fail++;
        $display("FAIL drain_strobe[%0d]: got re=%b a=%0d", i,
                 bus.ram_read_en, bus.ram_raddr);
      end
      tick();
      n_chk++;
      if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'(16 + i)) begin
        n_fail++;
        $display("FAIL drain_data[%0d]: got v=%b d=%h want v=1 d=%h",
                 i, bus.rd_valid, bus.rd_data, 8'(16 + i));
      end
    end
    set_in(1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    n_chk++;
    if (bus.rd_valid !== 1'b0 || bus.empty !== 1'b1 ||
        bus.almost_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL drain_end: got v=%b e=%b ae=%b want 0 1 1",
               bus.rd_valid, bus.empty, bus.almost_empty);
    end
  endtask

  task automatic test_wrap();
    logic [2:0] exp_wa [6];
    exp_wa = '{3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2};
    for (int i = 0; i < 5; i++) begin
      set_in(1'b1, 8'(32 + i), 1'b0, 1'b0);
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      set_in(1'b0, 8'h00, 1'b1, 1'b0);
      tick();
      n_chk++;
      if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'(32 + i)) begin
        n_fail++;
        $display("FAIL wrap_pop1[%0d]: got v=%b d=%h", i,
                 bus.rd_valid, bus.rd_data);
      end
    end
    for (int i = 0; i < 6; i++) begin
      set_in(1'b1, 8'(40 + i), 1'b0, 1'b0);
      #1;
      n_chk++;
      if (bus.ram_waddr !== exp_wa[i] || bus.ram_write_en !== 1'b1) begin
        n_fail++;
        $display("FAIL wrap_waddr[%0d]: got %0d want %0d", i,
                 bus.ram_waddr, exp_wa[i]);
      end
      tick();
      n_chk++;
      if (bus.count !== 4'(i + 1)) begin
        n_fail++;
        $display("FAIL wrap_cnt[%0d]: got %0d want %0d", i,
                 bus.count, i + 1);
      end
    end
    for (int i = 0; i < 6; i++) begin
      set_in(1'b0, 8'h00, 1'b1, 1'b0);
      tick();
      n_chk++;
      if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'(40 + i) ||
          bus.count !== 4'(5 - i)) begin
        n_fail++;
        $display("FAIL wrap_pop2[%0d]: got v=%b d=%h c=%0d", i,
                 bus.rd_valid, bus.rd_data, bus.count);
      end
    end
    set_in(1'b0, 8'h00, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_simultaneous();
    set_in(1'b1, 8'h30, 1'b1, 1'b0);
    #1;
    n_chk++;
    if (bus.ram_write_en !== 1'b1 || bus.ram_read_en !== 1'b0) begin
      n_fail++;
      $display("FAIL sim0_strobes: got we=%b re=%b want 1 0",
               bus.ram_write_en, bus.ram_read_en);
    end
    tick();
    n_chk++;
    if (bus.count !== 4'd1 || bus.rd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL sim0_res: got c=%0d v=%b want 1 0",
               bus.count, bus.rd_valid);
    end
    set_in(1'b1, 8'h31, 1'b0, 1'b0);
    tick();
    set_in(1'b1, 8'h32, 1'b0, 1'b0);
    tick();
    set_in(1'b1, 8'h33, 1'b1, 1'b0);
    #1;
    n_chk++;
    if (bus.ram_write_en !== 1'b1 || bus.ram_read_en !== 1'b1) begin
      n_fail++;
      $display("FAIL sim3_strobes: got we=%b re=%b want 1 1",
               bus.ram_write_en, bus.ram_read_en);
    end
    tick();
    n_chk++;
    if (bus.count !== 4'd3 || bus.rd_valid !== 1'b1 ||
        bus.rd_data !== 8'h30) begin
      n_fail++;
      $display("FAIL sim3_res: got c=%0d v=%b d=%h want 3 1 30",
               bus.count, bus.rd_valid, bus.rd_data);
    end
    for (int i = 0; i < 5; i++) begin
      set_in(1'b1, 8'(52 + i), 1'b0, 1'b0);
      tick();
    end
    set_in(1'b1, 8'h99, 1'b1, 1'b0);
    #1;
    n_chk++;
    if (bus.ram_write_en !== 1'b0 || bus.ram_read_en !== 1'b1) begin
      n_fail++;
      $display("FAIL sim8_strobes: got we=%b re=%b want 0 1",
               bus.ram_write_en, bus.ram_read_en);
    end
    tick();
    n_chk++;
    if (bus.count !== 4'd7 || bus.rd_data !== 8'h31) begin
      n_fail++;
      $display("FAIL sim8_res: got c=%0d d=%h want 7 31",
               bus.count, bus.rd_data);
    end
    for (int i = 0; i < 7; i++) begin
      set_in(1'b0, 8'h00, 1'b1, 1'b0);
      tick();
      n_chk++;
      if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'(50 + i)) begin
        n_fail++;
        $display("FAIL sim_drain[%0d]: got v=%b d=%h want %h", i,
                 bus.rd_valid, bus.rd_data, 8'(50 + i));
      end
    end
    set_in(1'b0, 8'h00, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 8'(64 + i), 1'b0, 1'b0);
      tick();
    end
    set_in(1'b0, 8'h00, 1'b1, 1'b0);
    tick();
    set_in(1'b1, 8'hEE, 1'b0, 1'b1);
    #1;
    n_chk++;
    if (bus.ram_write_en !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_we: got %b want 0", bus.ram_write_en);
    end
    n_chk++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'h40) begin
      n_fail++;
      $display("FAIL flush_rvld: got v=%b d=%h want 1 40",
               bus.rd_valid, bus.rd_data);
    end
    tick();
    n_chk++;
    if (bus.count !== 4'd0 || bus.empty !== 1'b1 ||
        bus.rd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_res: got c=%0d e=%b v=%b want 0 1 0",
               bus.count, bus.empty, bus.rd_valid);
    end
    set_in(1'b1, 8'h50, 1'b0, 1'b0);
    #1;
    n_chk++;
    if (bus.ram_waddr !== 3'd0) begin
      n_fail++;
      $display("FAIL flush_wptr: got %0d want 0", bus.ram_waddr);
    end
    tick();
    set_in(1'b0, 8'h00, 1'b1, 1'b0);
    tick();
    n_chk++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'h50) begin
      n_fail++;
      $display("FAIL flush_after: got v=%b d=%h want 1 50",
               bus.rd_valid, bus.rd_data);
    end
    set_in(1'b0, 8'h00, 1'b0, 1'b0);
    tick();
  endtask

`ifdef DPRAM_FIFO_ERR_EN
  task automatic test_err();
    set_in(1'b0, 8'h00, 1'b1, 1'b0);
    tick();
    set_in(1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    n_chk++;
    if (bus.underflow !== 1'b1 || bus.overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL err_unf: got u=%b o=%b want 1 0",
               bus.underflow, bus.overflow);
    end
    for (int i = 0; i < 8; i++) begin
      set_in(1'b1, 8'(i), 1'b0, 1'b0);
      tick();
    end
    set_in(1'b1, 8'h77, 1'b0, 1'b0);
    tick();
    set_in(1'b0, 8'h00, 1'b0, 1'b0);
    n_chk++;
    if (bus.overflow !== 1'b1 || bus.underflow !== 1'b1) begin
      n_fail++;
      $display("FAIL err_ovf: got o=%b u=%b want 1 1",
               bus.overflow, bus.underflow);
    end
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    n_chk++;
    if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL err_clr: got o=%b u=%b want 0 0",
               bus.overflow, bus.underflow);
    end
    set_in(1'b1, 8'h78, 1'b0, 1'b0);
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    set_in(1'b0, 8'h00, 1'b0, 1'b0);
    n_chk++;
    if (bus.overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL err_set_prio: got %b want 1", bus.overflow);
    end
    set_in(1'b0, 8'h00, 1'b0, 1'b1);
    tick();
    set_in(1'b0, 8'h00, 1'b0, 1'b0);
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    set_in(1'b0, 8'h00, 1'b0, 1'b0);
    bus.ram_rdata = 8'h00;
`ifdef DPRAM_FIFO_ERR_EN
    bus.err_clr = 1'b0;
`endif
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    test_reset();
    test_fill_drain();
    test_wrap();
    test_simultaneous();
    test_flush();
`ifdef DPRAM_FIFO_ERR_EN
    test_err();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
